// File: rtl/booth_job_controller_if.sv
// Handshake bundle between upstream, the job controller, the Booth multiplier and downstream.
// The slave view belongs to the controller; master is the environment side.
interface booth_job_controller_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_multiplicand;
  logic [3:0] in_multiplier;
  logic [3:0] mul_multiplicand;
  logic [3:0] mul_multiplier;
  logic       mul_start;
  logic       mul_busy;
  logic [7:0] mul_product;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic [7:0] job_count;
  logic       err;

  modport slave (
    input  in_valid, in_multiplicand, in_multiplier, mul_busy, mul_product, out_ready,
    output in_ready, mul_multiplicand, mul_multiplier, mul_start, out_valid, out_product,
           job_count, err
  );

  modport master (
    output in_valid, in_multiplicand, in_multiplier, mul_busy, mul_product, out_ready,
    input  in_ready, mul_multiplicand, mul_multiplier, mul_start, out_valid, out_product,
           job_count, err
  );
endinterface

// File: rtl/booth_job_controller.sv
// Sequences one operand pair at a time through an external Booth multiplier,
// with a per-wait-state watchdog that drops stuck jobs and raises a sticky err.
module booth_job_controller #(
  parameter int TIMEOUT = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  booth_job_controller_if.slave        bus
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, HOLD} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          expired;
  logic          abort;

  // cnt holds the number of cycles already spent in the current wait state
  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt   = state;
    abort = 1'b0;
    case (state)
      IDLE:      if (bus.in_valid) nxt = LAUNCH;
      LAUNCH:    nxt = WAIT_ACK;
      WAIT_ACK:
        if (bus.mul_busy) nxt = WAIT_DONE;
        else if (expired) begin nxt = IDLE; abort = 1'b1; end
      WAIT_DONE:
        if (!bus.mul_busy) nxt = HOLD;
        else if (expired)  begin nxt = IDLE; abort = 1'b1; end
      HOLD:      if (bus.out_ready) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.mul_start = (state == LAUNCH);
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mul_multiplicand <= 4'h0;
      bus.mul_multiplier   <= 4'h0;
      bus.out_product      <= 8'h00;
      bus.job_count        <= 8'h00;
      bus.err              <= 1'b0;
      cnt                  <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        bus.mul_multiplicand <= bus.in_multiplicand;
        bus.mul_multiplier   <= bus.in_multiplier;
      end
      if (state == WAIT_DONE && !bus.mul_busy) bus.out_product <= bus.mul_product;
      if (state == HOLD && bus.out_ready)      bus.job_count   <= bus.job_count + 8'd1;
      if (abort)                               bus.err         <= 1'b1;
      // any state change restarts the watchdog, so each wait state gets a fresh budget
      if (state != nxt)                                 cnt <= '0;
      else if (state == WAIT_ACK || state == WAIT_DONE) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_booth_job_controller.sv
// Directed bench for booth_job_controller with a small behavioural multiplier model.
module tb_booth_job_controller;
  localparam int TO = 32;

  logic clock;
  logic reset;
  int   checks;
  int   fails;

  booth_job_controller_if bif();

  booth_job_controller #(.TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // multiplier model: busy rises the edge after start and stays for busy_len cycles
  logic               model_en;
  logic               busy_extra;
  logic               m_busy;
  int                 busy_len;
  int                 m_cnt;
  logic [7:0]         m_prod;
  logic signed [7:0]  ea, eb;
  logic signed [15:0] pp;

  assign ea = {{4{bif.mul_multiplicand[3]}}, bif.mul_multiplicand};
  assign eb = {{4{bif.mul_multiplier[3]}}, bif.mul_multiplier};
  assign pp = ea * eb;
  assign bif.mul_busy    = m_busy | busy_extra;
  assign bif.mul_product = m_prod;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_prod <= 8'h00;
    end else if (bif.mul_start && model_en) begin
      m_busy <= 1'b1;
      m_cnt  <= busy_len;
      m_prod <= pp[7:0];
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    while (!bif.in_ready && n < 100) begin tick(); n++; end
    checks++;
    if (bif.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", bif.in_ready, n);
    end
    bif.in_multiplicand = a;
    bif.in_multiplier   = b;
    bif.in_valid        = 1'b1;
    tick();
    bif.in_valid        = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bif.out_valid && n < 100) begin tick(); n++; end
  endtask

  task automatic handshake();
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] got;
    bif.in_valid = 1'b0; bif.in_multiplicand = 4'h0; bif.in_multiplier = 4'h0;
    bif.out_ready = 1'b0; model_en = 1'b1; busy_extra = 1'b0; busy_len = 4;
    reset = 1'b0;
    #1 reset = 1'b1;
    tick(); tick();
    got = {bif.in_ready, bif.mul_start, bif.out_valid, bif.err, bif.job_count,
           bif.out_product, bif.mul_multiplicand, bif.mul_multiplier};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0}) begin
      fails++; $display("FAIL reset_state: got %h required %h", got, 28'h8000000);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", bif.in_ready, bif.out_valid);
    end
  endtask

  task automatic test_basic();
    int starts = 0;
    int n = 0;
    send_pair(4'b1100, 4'b1011);
    while (!bif.out_valid && n < 50) begin
      if (bif.mul_start) starts++;
      tick(); n++;
    end
    checks++;
    if (starts != 1) begin fails++; $display("FAIL basic_start_pulses: got %0d required 1", starts); end
    checks++;
    if (n != 6) begin fails++; $display("FAIL basic_latency: got %0d required 6", n); end
    checks++;
    if (bif.out_product !== 8'h14) begin fails++; $display("FAIL basic_product: got %h required 14", bif.out_product); end
    tick(); tick();
    checks++;
    if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_hold: out_valid=%b in_ready=%b required 1/0", bif.out_valid, bif.in_ready);
    end
    handshake();
    checks++;
    if ({bif.out_valid, bif.in_ready, bif.job_count} !== {1'b0, 1'b1, 8'd1}) begin
      fails++; $display("FAIL basic_done: out_valid=%b in_ready=%b job_count=%0d required 0/1/1",
                        bif.out_valid, bif.in_ready, bif.job_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [3] = '{4'h7, 4'h8, 4'h8};
    logic [3:0] bv [3] = '{4'h7, 4'h8, 4'h7};
    logic [7:0] ev [3] = '{8'h31, 8'h40, 8'hC8};
    int n;
    busy_len = 2;
    for (int i = 0; i < 3; i++) begin
      send_pair(av[i], bv[i]);
      checks++;
      if (bif.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b required 0", i, bif.in_ready); end
      wait_valid(n);
      checks++;
      if (bif.out_valid !== 1'b1 || bif.out_product !== ev[i]) begin
        fails++; $display("FAIL b2b_product[%0d]: valid=%b product=%h required 1/%h", i, bif.out_valid, bif.out_product, ev[i]);
      end
      handshake();
    end
    checks++;
    if (bif.job_count !== 8'd4) begin fails++; $display("FAIL b2b_job_count: got %0d required 4", bif.job_count); end
  endtask

  task automatic test_hold_stall();
    int n;
    send_pair(4'h3, 4'hE);
    wait_valid(n);
    bif.in_valid = 1'b1; bif.in_multiplicand = 4'h5; bif.in_multiplier = 4'h5;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bif.out_valid, bif.in_ready, bif.out_product, bif.job_count, bif.mul_multiplicand, bif.mul_multiplier}
          !== {1'b1, 1'b0, 8'hFA, 8'd4, 4'h3, 4'hE}) begin
        fails++; $display("FAIL stall[%0d]: valid=%b ready=%b product=%h count=%0d ops=%h/%h required 1/0/fa/4/3/e",
                          i, bif.out_valid, bif.in_ready, bif.out_product, bif.job_count,
                          bif.mul_multiplicand, bif.mul_multiplier);
      end
      tick();
    end
    bif.in_valid = 1'b0;
    handshake();
    checks++;
    if (bif.job_count !== 8'd5) begin fails++; $display("FAIL stall_job_count: got %0d required 5", bif.job_count); end
  endtask

  task automatic test_timeout();
    int n = 0;
    logic seen = 1'b0;
    model_en = 1'b0;
    send_pair(4'h2, 4'h3);
    while (!bif.in_ready && n < 100) begin
      if (bif.out_valid) seen = 1'b1;
      tick(); n++;
    end
    checks++;
    if (n != TO + 1) begin fails++; $display("FAIL ack_timeout_cycles: got %0d required %0d", n, TO + 1); end
    checks++;
    if ({bif.err, seen, bif.job_count} !== {1'b1, 1'b0, 8'd5}) begin
      fails++; $display("FAIL ack_timeout_state: err=%b saw_valid=%b count=%0d required 1/0/5", bif.err, seen, bif.job_count);
    end
    model_en = 1'b1; busy_len = 40; n = 0; seen = 1'b0;
    send_pair(4'h1, 4'h1);
    while (!bif.in_ready && n < 100) begin
      if (bif.out_valid) seen = 1'b1;
      tick(); n++;
    end
    checks++;
    if (n != TO + 2 || seen !== 1'b0 || bif.job_count !== 8'd5) begin
      fails++; $display("FAIL done_timeout: cycles=%0d saw_valid=%b count=%0d required %0d/0/5", n, seen, bif.job_count, TO + 2);
    end
    n = 0;
    while (m_busy && n < 100) begin tick(); n++; end
    busy_len = 3;
    send_pair(4'h1, 4'hF);
    wait_valid(n);
    checks++;
    if ({bif.out_valid, bif.out_product, bif.err} !== {1'b1, 8'hFF, 1'b1}) begin
      fails++; $display("FAIL post_timeout_job: valid=%b product=%h err=%b required 1/ff/1", bif.out_valid, bif.out_product, bif.err);
    end
    handshake();
    checks++;
    if (bif.job_count !== 8'd6) begin fails++; $display("FAIL post_timeout_count: got %0d required 6", bif.job_count); end
  endtask

  task automatic test_idle_busy();
    busy_extra = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bif.in_ready !== 1'b1 || bif.mul_start !== 1'b0) begin
      fails++; $display("FAIL idle_busy: in_ready=%b mul_start=%b required 1/0", bif.in_ready, bif.mul_start);
    end
    busy_extra = 1'b0;
  endtask

  task automatic test_reset_midjob();
    logic [27:0] got;
    logic seen = 1'b0;
    int n;
    busy_len = 4;
    send_pair(4'h5, 4'h5);
    tick(); tick(); tick();
    #3 reset = 1'b1;
    #1;
    got = {bif.in_ready, bif.mul_start, bif.out_valid, bif.err, bif.job_count,
           bif.out_product, bif.mul_multiplicand, bif.mul_multiplier};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0}) begin
      fails++; $display("FAIL async_reset: got %h required %h", got, 28'h8000000);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bif.out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_stale: saw out_valid=%b required 0", seen); end
    send_pair(4'h2, 4'h2);
    wait_valid(n);
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_product !== 8'h04) begin
      fails++; $display("FAIL reset_new_job: valid=%b product=%h required 1/04", bif.out_valid, bif.out_product);
    end
    handshake();
    checks++;
    if (bif.job_count !== 8'd1) begin fails++; $display("FAIL reset_job_count: got %0d required 1", bif.job_count); end
  endtask

  task automatic test_wrap();
    int n;
    busy_len = 1;
    for (int i = 0; i < 254; i++) begin
      send_pair(4'h3, 4'h2);
      wait_valid(n);
      handshake();
    end
    checks++;
    if (bif.job_count !== 8'hFF) begin fails++; $display("FAIL wrap_ff: got %h required ff", bif.job_count); end
    send_pair(4'h3, 4'h2);
    wait_valid(n);
    checks++;
    if (bif.out_product !== 8'h06) begin fails++; $display("FAIL wrap_product: got %h required 06", bif.out_product); end
    handshake();
    checks++;
    if (bif.job_count !== 8'h00) begin fails++; $display("FAIL wrap_zero: got %h required 00", bif.job_count); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_stall();
    test_timeout();
    test_idle_busy();
    test_reset_midjob();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
